// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with one-deep ready/valid output holding register.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q, rx_s_q;
  logic [1:0]      live_q;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            byte_done;

  // The synchronizer's reset value is not a real observation of the line, so
  // WAIT_HIGH only trusts rx_s once two live samples have propagated through it.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      live_q    <= 2'b00;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      live_q    <= {live_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= WAIT_HIGH;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    case (state_q)
      WAIT_HIGH: begin
        if (rx_s_q && live_q[1]) state_d = IDLE;
      end
      IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = WAIT_HIGH;
    endcase

    // Holding register: a completed byte is dropped only if the old one is still unaccepted.
    if (byte_done) begin
      if (rx_valid_q && !rx_ready) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver at 8 clocks per bit.
module tb_uart_receiver;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rstb;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rstb     (rstb),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor: collects accepted bytes and error pulses; the checker only reads these.
  logic [7:0] got_q[$];
  int         fe_cnt = 0, ov_cnt = 0, vld_cycles = 0, stab_err = 0;
  logic       prev_v = 1'b0, prev_r = 1'b0;
  logic [7:0] prev_d = '0;

  always @(negedge clk) begin
    if (rx_valid) vld_cycles++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (rstb && prev_v && !prev_r && (!rx_valid || rx_data != prev_d)) stab_err++;
    prev_v = rx_valid;
    prev_r = rx_ready;
    prev_d = rx_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  int rd_idx = 0;

  task automatic expect_rx(input string tag, input logic [7:0] exp);
    if (rd_idx < got_q.size()) begin
      chk(tag, 32'(got_q[rd_idx]), 32'(exp));
      rd_idx++;
    end else begin
      chk(tag, 32'h100, 32'(exp));
    end
  endtask

  function automatic int pending();
    return got_q.size() - rd_idx;
  endfunction

  int fe0, ov0, vc0;
  logic [7:0] exp_q[$];
  int exp_fe;

  initial begin
    rstb     = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    tick(3);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_frame_err", 32'(frame_err), 0);
    chk("reset_overrun", 32'(overrun), 0);
    rstb = 1'b1;
    tick(2 * CPB);

    // Single byte, consumer always ready
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vld_cycles;
    send_frame(8'h55, 1'b1);
    tick(2 * CPB);
    chk("b55_count", 32'(pending()), 1);
    expect_rx("b55_data", 8'h55);
    chk("b55_valid_cycles", 32'(vld_cycles - vc0), 1);
    chk("b55_frame_err", 32'(fe_cnt - fe0), 0);
    chk("b55_overrun", 32'(ov_cnt - ov0), 0);

    // Overrun: second byte arrives while first is still held
    fe0 = fe_cnt; ov0 = ov_cnt;
    rx_ready = 1'b0;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(2 * CPB);
    chk("ovr_pulses", 32'(ov_cnt - ov0), 1);
    chk("ovr_valid_held", 32'(rx_valid), 1);
    chk("ovr_data_held", 32'(rx_data), 32'h A3);
    chk("ovr_no_transfer", 32'(pending()), 0);
    rx_ready = 1'b1;
    tick(3);
    chk("ovr_transfer_count", 32'(pending()), 1);
    expect_rx("ovr_transfer_data", 8'hA3);
    chk("ovr_valid_cleared", 32'(rx_valid), 0);

    // Bad stop bit, line held low, then a good frame
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h12, 1'b0);
    rx = 1'b0;
    tick(3 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
    send_frame(8'h81, 1'b1);
    tick(2 * CPB);
    chk("ferr_pulses", 32'(fe_cnt - fe0), 1);
    chk("ferr_count", 32'(pending()), 1);
    expect_rx("ferr_next_data", 8'h81);

    // Start-bit glitch is ignored, receiver ready for the next frame
    fe0 = fe_cnt; vc0 = vld_cycles;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(4 * CPB);
    chk("glitch_no_valid", 32'(vld_cycles - vc0), 0);
    chk("glitch_no_ferr", 32'(fe_cnt - fe0), 0);
    send_frame(8'h5A, 1'b1);
    tick(2 * CPB);
    chk("glitch_next_count", 32'(pending()), 1);
    expect_rx("glitch_next_data", 8'h5A);

    // Reset mid-byte with line stuck low afterwards
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = vld_cycles;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    rx = 1'b0;
    tick(CPB / 2);
    rstb = 1'b0;
    tick(2);
    chk("mid_reset_rx_valid", 32'(rx_valid), 0);
    chk("mid_reset_rx_data", 32'(rx_data), 0);
    rstb = 1'b1;
    tick(12 * CPB);
    chk("mid_reset_no_valid", 32'(vld_cycles - vc0), 0);
    chk("mid_reset_no_ferr", 32'(fe_cnt - fe0), 0);
    chk("mid_reset_no_ovr", 32'(ov_cnt - ov0), 0);
    rx = 1'b1;
    tick(2 * CPB);
    send_frame(8'hC7, 1'b1);
    tick(2 * CPB);
    chk("mid_reset_count", 32'(pending()), 1);
    expect_rx("mid_reset_data", 8'hC7);

    // Back-to-back frames with no idle gap
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(2 * CPB);
    chk("b2b_count", 32'(pending()), 2);
    expect_rx("b2b_first", 8'h00);
    expect_rx("b2b_second", 8'hFF);
    chk("b2b_ferr", 32'(fe_cnt - fe0), 0);
    chk("b2b_ovr", 32'(ov_cnt - ov0), 0);

    // Random frames: good bytes must arrive in order, bad stop bits only raise frame_err
    fe0 = fe_cnt; ov0 = ov_cnt;
    exp_fe = 0;
    for (int k = 0; k < 24; k++) begin
      logic [7:0] b;
      logic       bad;
      int         gap;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      gap = $urandom_range(0, 2 * CPB);
      send_frame(b, ~bad);
      if (bad) begin
        exp_fe++;
        gap += CPB;
      end else begin
        exp_q.push_back(b);
      end
      tick(gap);
    end
    tick(3 * CPB);
    chk("rand_count", 32'(pending()), 32'(exp_q.size()));
    foreach (exp_q[i]) expect_rx($sformatf("rand_byte%0d", i), exp_q[i]);
    chk("rand_ferr", 32'(fe_cnt - fe0), 32'(exp_fe));
    chk("rand_ovr", 32'(ov_cnt - ov0), 0);

    chk("hold_stability", 32'(stab_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rstb  input  1  reset, synchronous, active-low.
REQ-004 Port: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 Port: rx_data  output  8  received byte; valid while rx_valid=1.
REQ-006 Port: rx_valid  output  1  byte available; held until accepted.
REQ-007 Port: rx_ready  input  1  consumer accept; a transfer occurs on any cycle with rx_valid=1 and rx_ready=1.
REQ-008 Port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 Port: overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s); synchronizer flops reset to 1.
REQ-011 FSM states SHALL be WAIT_HIGH, IDLE, START, DATA, STOP.
REQ-012 WAIT_HIGH: on rx_s=1 go to IDLE; otherwise stay.
REQ-013 IDLE: on rx_s=0 go to START; clear bit counter and cycle counter.
REQ-014 START: at cycle counter = CLKS_PER_BIT/2-1 (integer divide), sample rx_s; 0 -> DATA with cycle counter cleared; 1 -> glitch, return to IDLE with no output activity.
REQ-015 DATA: every CLKS_PER_BIT cycles, sample rx_s into shift register, LSB first; after the 8th sample go to STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles, sample rx_s; 1 -> byte complete, go to IDLE; 0 -> frame_err=1 for exactly that cycle, byte discarded, go to WAIT_HIGH.
REQ-017 A complete byte SHALL drive rx_data and rx_valid=1 on the cycle after the stop-bit sample.
REQ-018 rx_data SHALL remain stable while rx_valid=1 and no transfer occurs.
REQ-019 A transfer with no byte completing in the same cycle SHALL clear rx_valid on the next cycle.
REQ-020 A byte completing while rx_valid=1 and rx_ready=0: new byte dropped, old rx_data kept, overrun=1 for one cycle.
REQ-021 A byte completing on a transfer cycle (rx_valid=1, rx_ready=1): new byte loaded, rx_valid stays 1, no overrun.
REQ-022 IDLE SHALL accept a start bit on the first cycle after the stop-bit sample; back-to-back frames need no idle gap.
REQ-023 rx_valid SHALL be independent of reception; a byte may be in reception while the previous one is pending.

Reset
REQ-024 When rstb=0 on a clock edge, on the next cycle: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, counters=0, shift register=0, state=WAIT_HIGH.
REQ-025 Reset mid-frame SHALL abort the frame with no rx_valid, frame_err or overrun.
REQ-026 After reset, no start bit SHALL be detected until rx_s has been 1 for at least one cycle.

Verification (CLKS_PER_BIT=8)
REQ-027 Frame 0x55, rx_ready=1 -> rx_valid high exactly 1 cycle with rx_data=0x55; frame_err=0, overrun=0.
REQ-028 Frame 0xA3, rx_ready=0, then frame 0x3C -> overrun pulses once; rx_data stays 0xA3; raising rx_ready gives a 0xA3 transfer, then rx_valid=0.
REQ-029 Frame 0x12 with stop bit 0, rx held low 3 bit times, then high, then frame 0x81 -> one frame_err pulse, no rx_valid for 0x12; 0x81 received correctly.
REQ-030 rx low pulse of 2 cycles, then high -> no rx_valid or frame_err; FSM back in IDLE.
REQ-031 rstb asserted mid-byte with rx held low after release -> all outputs 0, no reception; rx high, then frame 0xC7 -> 0xC7 received.
REQ-032 Frames 0x00 and 0xFF back-to-back with zero idle, rx_ready=1 -> two rx_valid pulses with 0x00 then 0xFF; no errors.
